// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package cnt_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int unsigned CNT_SEQ_LOAD_VAL = 32'd0;

  function automatic logic state_is_busy(input state_t s);
    logic v;
    case (s)
      ST_LOAD, ST_RUN, ST_DONE: v = 1'b1;
      default:                  v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Sequencer wrapped around a generic up-counter: emits a periodic or one-shot tick per interval.
// Optional tick counter output enabled by defining CNT_SEQ_TICK_CNT_EN.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int TCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             tick,
  output logic             done,
  output logic             busy
`ifdef CNT_SEQ_TICK_CNT_EN
  ,
  output logic [TCW-1:0]   tick_count
`endif
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_tick;
  logic             r_done;
  logic             w_match;
  logic             w_start_acc;

  // Next-state decode; stop overrides start and the terminal-count match everywhere
  always_comb begin
    w_next_state = r_state;
    w_match      = 1'b0;
    w_start_acc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_start_acc  = 1'b1;
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (cnt_out == r_period) begin
          w_match      = 1'b1;
          w_next_state = r_mode ? ST_DONE : ST_LOAD;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_period <= {WIDTH{1'b0}};
      r_mode   <= 1'b0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tick  <= w_match;
      r_done  <= w_match & r_mode;
      if (w_start_acc) begin
        r_period <= period;
        r_mode   <= one_shot;
      end
    end
  end

`ifdef CNT_SEQ_TICK_CNT_EN
  logic [TCW-1:0] r_tick_count;

  // Count completed intervals since the last accepted start; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_count <= {TCW{1'b0}};
    end else if (w_start_acc) begin
      r_tick_count <= {TCW{1'b0}};
    end else if (w_match) begin
      r_tick_count <= r_tick_count + {{(TCW-1){1'b0}}, 1'b1};
    end
  end

  assign tick_count = r_tick_count;
`endif

  // Counter controls are pure state decodes so the counter sees no combinational path from cnt_out
  assign load   = (r_state == ST_LOAD);
  assign enab   = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign busy   = state_is_busy(r_state);
  assign cnt_in = WIDTH'(CNT_SEQ_LOAD_VAL);
  assign tick   = r_tick;
  assign done   = r_done;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl with a behavioural up-counter closing the loop.
module tb_cnt_seq_ctrl;

`ifdef CNT_SEQ_TICK_CNT_EN
  localparam int TCW = 2;
`else
  localparam int TCW = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [4:0] period = 5'd0;
  logic [4:0] cnt_out;
  logic       load, enab, tick, done, busy;
  logic [4:0] cnt_in;
`ifdef CNT_SEQ_TICK_CNT_EN
  logic [TCW-1:0] tick_count;
`endif

  int checks = 0;
  int errors = 0;

  cnt_seq_ctrl #(.WIDTH(5), .TCW(TCW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .period(period), .cnt_out(cnt_out), .load(load), .enab(enab),
    .cnt_in(cnt_in), .tick(tick), .done(done), .busy(busy)
`ifdef CNT_SEQ_TICK_CNT_EN
    , .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  // Generic up-counter: load has priority over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_out <= 5'd0;
    else if (load) cnt_out <= cnt_in;
    else if (enab) cnt_out <= cnt_out + 5'd1;
  end

  // Request a start; returns at the negedge of the LOAD cycle (cycle n)
  task automatic launch(input logic [4:0] p, input logic os);
    @(negedge clk);
    start = 1'b1; period = p; one_shot = os;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({load, enab, tick, done, busy, cnt_in} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got=%b want=0", {load, enab, tick, done, busy, cnt_in});
    end
    rst = 1'b1;
    launch(5'd3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (enab !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_active enab=%b busy=%b want 1 1", enab, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({load, enab, tick, done, busy} !== 5'd0) begin
      errors++; $display("FAIL midrun_reset got=%b want=00000", {load, enab, tick, done, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle busy=%b load=%b want 0 0", busy, load);
    end
  endtask

  task automatic test_periodic();
    launch(5'd3, 1'b0);
    checks++;
    if (load !== 1'b1) begin
      errors++; $display("FAIL periodic_load0 got=%b want=1", load);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== (k % 5 == 0) || (tick && load !== 1'b1) || done !== 1'b0) begin
        errors++; $display("FAIL periodic_p3 k=%0d tick=%b load=%b done=%b", k, tick, load, done);
      end
    end
    halt();
    checks++;
    if (busy !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL periodic_stop busy=%b tick=%b want 0 0", busy, tick);
    end
  endtask

  task automatic test_one_shot();
    launch(5'd2, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== (k == 4) || done !== (k == 4) || busy !== (k <= 4) || load !== 1'b0) begin
        errors++; $display("FAIL one_shot k=%0d tick=%b done=%b busy=%b load=%b", k, tick, done, busy, load);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [4:0] max_cnt;
    launch(5'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== (k % 2 == 0)) begin
        errors++; $display("FAIL p0_tick k=%0d got=%b want=%b", k, tick, (k % 2 == 0));
      end
    end
    halt();
    launch(5'd31, 1'b0);
    max_cnt = 5'd0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (cnt_out > max_cnt) max_cnt = cnt_out;
      if (k == 32 || k == 33 || k == 66) begin
        checks++;
        if (tick !== (k != 32)) begin
          errors++; $display("FAIL p31_tick k=%0d got=%b want=%b", k, tick, (k != 32));
        end
      end else if (tick !== 1'b0) begin
        checks++; errors++; $display("FAIL p31_spurious k=%0d got=1 want=0", k);
      end
    end
    checks++;
    if (max_cnt !== 5'd31) begin
      errors++; $display("FAIL p31_max got=%0d want=31", max_cnt);
    end
    halt();
  endtask

  task automatic test_stop();
    launch(5'd3, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (cnt_out !== 5'd3) begin
      errors++; $display("FAIL stop_match_setup cnt=%0d want=3", cnt_out);
    end
    halt();
    checks++;
    if ({tick, done, busy, load} !== 4'd0) begin
      errors++; $display("FAIL stop_in_match got=%b want=0000", {tick, done, busy, load});
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_ignore_start();
    launch(5'd3, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b1; period = 5'd7; one_shot = 1'b1; end
      if (k == 3) start = 1'b0;
      checks++;
      if (tick !== (k % 5 == 0) || done !== 1'b0) begin
        errors++; $display("FAIL busy_start_ignored k=%0d tick=%b done=%b", k, tick, done);
      end
    end
    halt();
  endtask

`ifdef CNT_SEQ_TICK_CNT_EN
  task automatic test_tick_count();
    logic [1:0] exp_tc [5];
    exp_tc[0] = 2'd1; exp_tc[1] = 2'd2; exp_tc[2] = 2'd3; exp_tc[3] = 2'd0; exp_tc[4] = 2'd1;
    launch(5'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        checks++;
        if (tick_count !== exp_tc[k/2-1]) begin
          errors++; $display("FAIL tick_count k=%0d got=%0d want=%0d", k, tick_count, exp_tc[k/2-1]);
        end
      end
    end
    halt();
    @(negedge clk);
    checks++;
    if (tick_count !== 2'd1) begin
      errors++; $display("FAIL tick_count_hold got=%0d want=1", tick_count);
    end
    launch(5'd4, 1'b0);
    checks++;
    if (tick_count !== 2'd0) begin
      errors++; $display("FAIL tick_count_clear got=%0d want=0", tick_count);
    end
    halt();
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_one_shot();
    test_boundaries();
    test_stop();
    test_ignore_start();
`ifdef CNT_SEQ_TICK_CNT_EN
    test_tick_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
